// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high-tick count and period of a tick-sampled PWM input.
// Define PWM_DECODER_GLITCH_FILTER_EN to add a 3-sample agreement filter on the input.
`timescale 1ns/1ps
module pwm_decoder (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       pwm_in,
    input  logic       tick_in,
    input  logic       enable,
    output logic [7:0] level_out,
    output logic [9:0] period_out,
    output logic       valid_out,
    output logic       stuck_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

    // One tick short of the 512-tick rise timeout.
    localparam logic [9:0] CNT_LAST = 10'd511;

    function automatic logic [7:0] sat_level(input logic [9:0] cnt);
        return (cnt > 10'd255) ? 8'hFF : cnt[7:0];
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] cnt, input logic inc);
        return (inc && (cnt != 10'h3FF)) ? cnt + 10'd1 : cnt;
    endfunction

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       last_q, last_d;
    logic [9:0] period_cnt_q, period_cnt_d;
    logic [9:0] high_cnt_q, high_cnt_d;
    logic [7:0] level_q, level_d;
    logic [9:0] period_q, period_d;
    logic       valid_q, valid_d;
    logic       stuck_q, stuck_d;
    logic       cur;
    logic       rise;

    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    // cur follows the synchronized input only once three tick samples agree.
    always_comb begin
        hist_d = hist_q;
        filt_d = filt_q;
        cur    = filt_q;
        if (tick_in) begin
            cur    = ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) ? sync2_q : filt_q;
            hist_d = {hist_q[0], sync2_q};
            filt_d = cur;
        end
        if (!enable) begin
            hist_d = 2'b00;
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
`else
    always_comb begin
        cur = sync2_q;
    end
`endif

    assign rise = cur & ~last_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        level_d      = level_q;
        period_d     = period_q;
        stuck_d      = stuck_q;
        valid_d      = 1'b0;

        if (!enable) begin
            state_d      = ST_IDLE;
            last_d       = 1'b0;
            period_cnt_d = 10'd0;
            high_cnt_d   = 10'd0;
        end else if (tick_in) begin
            last_d = cur;
            case (state_q)
                ST_IDLE, ST_MEASURE: begin
                    if (rise) begin
                        // The first rise after IDLE only anchors the period.
                        if (state_q == ST_MEASURE) begin
                            level_d  = sat_level(high_cnt_q);
                            period_d = period_cnt_q;
                            stuck_d  = 1'b0;
                            valid_d  = 1'b1;
                        end
                        state_d      = ST_MEASURE;
                        period_cnt_d = 10'd1;
                        high_cnt_d   = 10'd1;
                    end else if (period_cnt_q == CNT_LAST) begin
                        state_d  = ST_STUCK;
                        level_d  = cur ? 8'hFF : 8'h00;
                        period_d = 10'd0;
                        stuck_d  = 1'b1;
                        valid_d  = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + 10'd1;
                        if (state_q == ST_MEASURE) begin
                            high_cnt_d = sat_inc(high_cnt_q, cur);
                        end
                    end
                end
                ST_STUCK: begin
                    // stuck_out stays set until a full period is published.
                    if (rise) begin
                        state_d      = ST_MEASURE;
                        period_cnt_d = 10'd1;
                        high_cnt_d   = 10'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            last_q       <= 1'b0;
            period_cnt_q <= 10'd0;
            high_cnt_q   <= 10'd0;
            level_q      <= 8'd0;
            period_q     <= 10'd0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            last_q       <= last_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            level_q      <= level_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
        end
    end

    assign level_out  = level_q;
    assign period_out = period_q;
    assign valid_out  = valid_q;
    assign stuck_out  = stuck_q;

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The block SHALL have ports: clk_in  input  1  sole clock, all state on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-high.
REQ-003 pwm_in  input  1  asynchronous PWM waveform to measure (nominal period 256 ticks).
REQ-004 tick_in  input  1  one-clk_in-cycle sample strobe; all measurement advances only on tick_in cycles.
REQ-005 enable  input  1  measurement enable; low holds block idle.
REQ-006 level_out  output  8  measured high-tick count of last complete period, saturated to 255.
REQ-007 period_out  output  10  measured tick count of last complete period; 0 when stuck.
REQ-008 valid_out  output  1  one-cycle pulse when level_out/period_out update.
REQ-009 stuck_out  output  1  no rising edge seen within timeout; cleared on next valid measured period.

Function
REQ-010 pwm_in SHALL pass through a two-flop synchronizer (sync2) before any use.
REQ-011 On each tick_in cycle: cur = filtered sync2 (see REQ-030); rise = cur & ~last; last <= cur.
REQ-012 States SHALL be IDLE, MEASURE, STUCK; encoded state not an output.
REQ-013 IDLE: period_cnt (10b) increments per tick; rise -> MEASURE with period_cnt=1, high_cnt=1, no publish.
REQ-014 MEASURE, tick without rise: period_cnt += 1; high_cnt += cur (10b, no wrap below 1023).
REQ-015 MEASURE, tick with rise: publish level_out = min(high_cnt,255), period_out = period_cnt, stuck_out=0, valid_out=1; then period_cnt=1, high_cnt=1.
REQ-016 Timeout: in IDLE or MEASURE, tick that would make period_cnt 512 without rise -> STUCK; publish level_out = cur?255:0, period_out=0, stuck_out=1, valid_out=1.
REQ-017 STUCK: counters frozen, no further publishes; rise -> MEASURE with period_cnt=1, high_cnt=1, stuck_out stays 1 until REQ-015 publish.
REQ-018 Publish latency: outputs and valid_out SHALL be registered, visible the clk_in cycle after the qualifying tick_in cycle; valid_out high exactly one cycle.
REQ-019 Ticks on consecutive clk_in cycles SHALL be supported (tick_in tied high).
REQ-020 enable low: state -> IDLE, counters=0, last=0, valid_out=0; level_out, period_out, stuck_out hold.
REQ-021 enable rising: IDLE restarts; first publish only after two rises or timeout.
REQ-022 Non-tick cycles SHALL change nothing except synchronizer flops and valid_out clear.
REQ-023 A 256-tick PWM with duty N (0<N<256) SHALL decode to level_out=N, period_out=256 in steady state.

Reset
REQ-024 rst_in high SHALL immediately force: state IDLE, sync flops 0, last 0, counters 0, level_out 0, period_out 0, valid_out 0, stuck_out 0.
REQ-025 Reset asserted mid-period SHALL discard partial counts; no publish on deassert.
REQ-026 Release SHALL be synchronous to clk_in; first tick after release counts as IDLE tick.

Configuration
REQ-027 Macro PWM_DECODER_GLITCH_FILTER_EN selects input filtering.
REQ-028 Defined: cur changes only after 3 consecutive tick samples of sync2 agree; filter history resets to 0.
REQ-029 Defined: each edge delayed exactly 2 ticks; steady-state duty/period results unchanged; pulses of 1-2 ticks rejected.
REQ-030 Undefined: cur = sync2 sampled at tick; no filter logic synthesized.

Verification
REQ-031 Loopback from 8-bit tick-driven PWM generator, level 128, tick_in=1 -> from 3rd rise onward valid every 256 cycles, level_out=128, period_out=256, stuck_out=0.
REQ-032 Generator level 0 (pwm_in low), enable high -> after 511 ticks valid pulse, level_out=0, period_out=0, stuck_out=1; then no more valids.
REQ-033 pwm_in held high after MEASURE -> timeout, level_out=255, stuck_out=1; then level 64 resumes -> second publish level_out=64, stuck_out=0.
REQ-034 Level 200 loopback, tick_in every 4th clk -> level_out=200, period_out=256; valid_out one clk wide.
REQ-035 rst_in pulsed mid-period (level 100) -> all outputs 0 within same cycle; next publish level_out=100 after two rises.
REQ-036 PWM_DECODER_GLITCH_FILTER_EN defined, 1-tick high glitch in low phase of level 50 -> level_out=50 unchanged; undefined -> early publish with corrupted period.
